// File: rtl/debug_ctrl.sv
// CPU debug controller: run/step/breakpoint control, memory-browse address
// and a multiplexed seven-segment display of pc or mem_data.
module debug_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 16,
  parameter int DEB_CYC  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cont,
  input  logic              step,
  input  logic              mem,
  input  logic              inc,
  input  logic              dec,
  input  logic              bkpt_en,
  input  logic [ADDR_W-1:0] bkpt_addr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] mem_data,
  output logic              run,
  output logic [ADDR_W-1:0] ddu_addr,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [15:0]       led
);

  localparam logic [1:0] S_HALT  = 2'b00;
  localparam logic [1:0] S_STEP  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_BREAK = 2'b11;

  localparam int CNT_W  = $clog2(DEB_CYC + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W  = (DIGITS * 4 > DATA_W) ? DIGITS * 4 : DATA_W;

  logic [2:0]        w_btn;
  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_level;
  logic [2:0]        r_pulse;
  logic [CNT_W-1:0]  r_debCnt [3];

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic              w_run;
  logic              w_bkptHit;
  logic              w_stepPulse;
  logic              w_incPulse;
  logic              w_decPulse;

  logic [ADDR_W-1:0] r_addr;
  logic [SCAN_W-1:0] r_scanCnt;
  logic [DIG_W-1:0]  r_digit;
  logic [DATA_W-1:0] w_value;
  logic [EXT_W-1:0]  w_valueExt;
  logic [3:0]        w_nibble;
  logic [DIGITS-1:0] w_an;
  logic [6:0]        w_seg;

  assign w_btn       = {dec, inc, step};
  assign w_stepPulse = r_pulse[0];
  assign w_incPulse  = r_pulse[1];
  assign w_decPulse  = r_pulse[2];

  // Debounced level only flips after DEB_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_pulse <= '0;
      for (int b = 0; b < 3; b++) r_debCnt[b] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int b = 0; b < 3; b++) begin
        r_pulse[b] <= 1'b0;
        if (r_sync2[b] == r_level[b]) begin
          r_debCnt[b] <= '0;
        end else if (r_debCnt[b] == CNT_W'(DEB_CYC - 1)) begin
          r_level[b]  <= r_sync2[b];
          r_debCnt[b] <= '0;
          r_pulse[b]  <= r_sync2[b];
        end else begin
          r_debCnt[b] <= r_debCnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_bkptHit = bkpt_en && (pc[ADDR_W-1:0] == bkpt_addr);

  always_comb begin
    w_nextState = r_state;
    w_run       = 1'b0;
    case (r_state)
      S_HALT: begin
        if (cont) w_nextState = S_RUN;
        else if (w_stepPulse) w_nextState = S_STEP;
      end
      S_STEP: begin
        w_run       = 1'b1;
        w_nextState = S_HALT;
      end
      S_RUN: begin
        // A breakpoint match stalls the CPU in the very cycle it is seen.
        w_run = !w_bkptHit;
        if (!cont) w_nextState = S_HALT;
        else if (w_bkptHit) w_nextState = S_BREAK;
      end
      default: begin
        if (!cont) w_nextState = S_HALT;
        else if (w_stepPulse) w_nextState = S_STEP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_HALT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
    end else if (w_incPulse && !w_decPulse) begin
      r_addr <= r_addr + 1'b1;
    end else if (w_decPulse && !w_incPulse) begin
      r_addr <= r_addr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scanCnt <= '0;
      r_digit   <= '0;
    end else if (r_scanCnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scanCnt <= '0;
      r_digit   <= (r_digit == DIG_W'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
    end else begin
      r_scanCnt <= r_scanCnt + 1'b1;
    end
  end

  assign w_value    = mem ? mem_data : pc;
  assign w_valueExt = EXT_W'(w_value);
  assign w_nibble   = w_valueExt[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_an          = '1;
    w_an[r_digit] = 1'b0;
  end

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_nibble)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      default: w_seg = 7'b0001110;
    endcase
  end

  assign run      = w_run;
  assign ddu_addr = r_addr;
  assign an       = w_an;
  assign seg      = w_seg;
  assign dp       = !((r_digit == '0) && (r_state == S_BREAK));
  assign led      = {r_state, 6'b000000, 8'(r_addr)};

endmodule

// File: tb/tb_debug_ctrl.sv
// Directed bench for debug_ctrl: expectations are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cont = 1'b0;
  logic        step = 1'b0;
  logic        mem = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        bkpt_en = 1'b0;
  logic [7:0]  bkpt_addr = 8'h00;
  logic [31:0] pc = 32'h0;
  logic [31:0] mem_data = 32'h0;
  logic        run;
  logic [7:0]  ddu_addr;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] led;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  debug_ctrl #(
    .ADDR_W(8), .DATA_W(32), .DIGITS(8), .SCAN_DIV(4), .DEB_CYC(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cont(cont), .step(step), .mem(mem),
    .inc(inc), .dec(dec), .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
    .pc(pc), .mem_data(mem_data), .run(run), .ddu_addr(ddu_addr),
    .an(an), .seg(seg), .dp(dp), .led(led)
  );

  always #5 clk = ~clk;

  task automatic expectValue(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: observed=%h expected=<none>", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // which: 0 step, 1 inc, 2 dec, 3 inc+dec together
  task automatic applyStimulus(input int which);
    @(negedge clk);
    step = (which == 0);
    inc  = (which == 1) || (which == 3);
    dec  = (which == 2) || (which == 3);
    repeat (10) @(negedge clk);
    step = 1'b0;
    inc  = 1'b0;
    dec  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int          runCount;
    logic [1:0]  stDuring;
    logic [1:0]  stAfter;
    logic        gotAfter;
    logic        prevRun;
    logic [7:0]  prevAn;
    logic        found;
    logic        hit;
    logic        r;
    logic [1:0]  ledAtRun;

    // Reset state
    #12;
    expectValue("rst_run", 32'd0);
    expectValue("rst_addr", 32'h00);
    expectValue("rst_an", 32'hFE);
    expectValue("rst_led", 32'h0000);
    expectValue("rst_dp", 32'd1);
    expectValue("rst_seg", 32'h40);
    checkOutput(run);
    checkOutput(ddu_addr);
    checkOutput(an);
    checkOutput(led);
    checkOutput(dp);
    checkOutput(seg);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Step held high for 10 cycles from HALT
    expectValue("step_run_count", 32'd1);
    expectValue("step_state_during", 32'd1);
    expectValue("step_state_after", 32'd0);
    step = 1'b1;
    runCount = 0;
    stDuring = 2'b11;
    stAfter  = 2'b11;
    gotAfter = 1'b0;
    prevRun  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) step = 1'b0;
      if (prevRun && !gotAfter) begin
        stAfter  = led[15:14];
        gotAfter = 1'b1;
      end
      if (run) begin
        runCount++;
        if (runCount == 1) stDuring = led[15:14];
      end
      prevRun = run;
      @(negedge clk);
    end
    checkOutput(runCount);
    checkOutput(stDuring);
    checkOutput(stAfter);
    repeat (10) @(negedge clk);

    // Step toggled every cycle: bounce must be filtered out
    expectValue("toggle_run_count", 32'd0);
    step = 1'b1; @(negedge clk);
    step = 1'b0; @(negedge clk);
    step = 1'b1; @(negedge clk);
    step = 1'b0;
    runCount = 0;
    for (int i = 0; i < 15; i++) begin
      if (run) runCount++;
      @(negedge clk);
    end
    checkOutput(runCount);

    // Browse address wrap and simultaneous inc/dec
    expectValue("dec_wrap_addr", 32'hFF);
    expectValue("dec_wrap_led", 32'hFF);
    applyStimulus(2);
    checkOutput(ddu_addr);
    checkOutput(led[7:0]);
    expectValue("inc_wrap_addr", 32'h00);
    expectValue("inc_wrap_led", 32'h00);
    applyStimulus(1);
    checkOutput(ddu_addr);
    checkOutput(led[7:0]);
    expectValue("inc_addr", 32'h01);
    applyStimulus(1);
    checkOutput(ddu_addr);
    expectValue("incdec_addr", 32'h01);
    applyStimulus(3);
    checkOutput(ddu_addr);

    // Display scan: align on the 7F -> FE transition
    pc = 32'h1234ABCD;
    mem = 1'b0;
    mem_data = 32'h000000FA;
    expectValue("scan_sync", 32'd1);
    found  = 1'b0;
    prevAn = an;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (prevAn == 8'h7F && an == 8'hFE) found = 1'b1;
      prevAn = an;
    end
    checkOutput(found);
    expectValue("scan_d0_an", 32'hFE);
    expectValue("scan_d0_seg", 32'h21);
    checkOutput(an);
    checkOutput(seg);
    repeat (4) @(negedge clk);
    expectValue("scan_d1_an", 32'hFD);
    expectValue("scan_d1_seg", 32'h46);
    checkOutput(an);
    checkOutput(seg);
    repeat (28) @(negedge clk);
    expectValue("scan_wrap_an", 32'hFE);
    checkOutput(an);
    expectValue("mem_sel_seg", 32'h08);
    mem = 1'b1;
    #1;
    checkOutput(seg);
    mem = 1'b0;

    // Breakpoint during free-run
    pc = 32'h0;
    bkpt_addr = 8'h10;
    bkpt_en = 1'b1;
    @(negedge clk);
    cont = 1'b1;
    expectValue("bkpt_led_run", 32'd2);
    expectValue("bkpt_reached", 32'd1);
    expectValue("bkpt_run_comb", 32'd0);
    hit = 1'b0;
    ledAtRun = 2'b00;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (pc == 32'h8) ledAtRun = led[15:14];
      if (pc == 32'h10) begin
        hit = 1'b1;
      end else begin
        r = run;
        @(posedge clk);
        #1;
        if (r) pc = pc + 1;
      end
    end
    checkOutput(ledAtRun);
    checkOutput(hit);
    checkOutput(run);
    @(posedge clk);
    #1;
    expectValue("break_state", 32'd3);
    expectValue("break_run", 32'd0);
    checkOutput(led[15:14]);
    checkOutput(run);
    @(negedge clk);
    cont = 1'b0;
    @(posedge clk);
    #1;
    expectValue("break_to_halt", 32'd0);
    checkOutput(led[15:14]);
    @(negedge clk);
    expectValue("halt_step_runs", 32'd1);
    step = 1'b1;
    runCount = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) step = 1'b0;
      if (run) runCount++;
      @(negedge clk);
    end
    checkOutput(runCount);
    repeat (10) @(negedge clk);

    // Reset asserted mid-RUN, with inc held across release
    bkpt_en = 1'b0;
    cont = 1'b1;
    repeat (3) @(negedge clk);
    expectValue("pre_reset_run", 32'd1);
    checkOutput(run);
    #2;
    reset_n = 1'b0;
    inc = 1'b1;
    #1;
    expectValue("async_rst_run", 32'd0);
    expectValue("async_rst_led", 32'h0000);
    checkOutput(run);
    checkOutput(led);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    expectValue("release_halt", 32'd0);
    checkOutput(led[15:14]);
    @(posedge clk);
    #1;
    expectValue("resume_run", 32'd2);
    checkOutput(led[15:14]);
    repeat (2) @(negedge clk);
    expectValue("held_inc_early", 32'h00);
    checkOutput(ddu_addr);
    repeat (10) @(negedge clk);
    expectValue("held_inc_late", 32'h01);
    checkOutput(ddu_addr);
    inc = 1'b0;
    cont = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameter ADDR_W, 8: browse-address width, legal range 1..16.
REQ-002 Parameter DATA_W, 32: width of displayed CPU values.
REQ-003 Parameter DIGITS, 8: number of seven-segment digits scanned.
REQ-004 Parameter SCAN_DIV, 16: clock cycles per displayed digit, at least 1.
REQ-005 Parameter DEB_CYC, 4: debounce stability window in cycles, at least 1.
REQ-006 clk  in  1  single system clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 cont  in  1  level; 1 requests free-run.
REQ-009 step  in  1  push-button; each debounced press requests one run cycle.
REQ-010 mem  in  1  1 = display mem_data; 0 = display pc.
REQ-011 inc, dec  in  1 each  push-buttons that increment or decrement ddu_addr.
REQ-012 bkpt_en  in  1  enables the breakpoint in free-run.
REQ-013 bkpt_addr  in  ADDR_W  breakpoint address.
REQ-014 pc  in  DATA_W  CPU program counter.
REQ-015 mem_data  in  DATA_W  CPU memory word at ddu_addr.
REQ-016 run  out  1  CPU clock enable.
REQ-017 ddu_addr  out  ADDR_W  memory browse address.
REQ-018 an  out  DIGITS  digit enables, active-low, one-hot.
REQ-019 seg  out  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}.
REQ-020 dp  out  1  decimal point, active-low.
REQ-021 led  out  16  status lamps.

Function
REQ-022 step, inc and dec SHALL each pass through a 2-FF synchroniser and a debounce counter:
- counter clears while the synchronised value equals the debounced level;
- debounced level toggles after DEB_CYC consecutive cycles of difference;
- a one-cycle pulse SHALL follow each debounced rising edge.
REQ-023 The run-control FSM SHALL have states HALT=00, STEP=01, RUN=10, BREAK=11.
REQ-024 HALT transitions:
- cont=1 goes to RUN, taking priority over a simultaneous step pulse, which is discarded;
- a step pulse alone goes to STEP.
REQ-025 STEP SHALL last exactly one cycle with run=1, then return to HALT.
REQ-026 RUN transitions:
- run=1 every cycle;
- cont=0 goes to HALT;
- bkpt_en=1 and pc[ADDR_W-1:0]==bkpt_addr goes to BREAK, with run=0 combinationally in that same cycle.
REQ-027 BREAK transitions:
- run=0;
- cont=0 goes to HALT;
- a step pulse goes to STEP, allowing a single step past the breakpoint.
REQ-028 ddu_addr inc/dec rules:
- an inc pulse adds 1 modulo 2^ADDR_W;
- a dec pulse subtracts 1 modulo 2^ADDR_W;
- simultaneous inc and dec pulses leave ddu_addr unchanged.
REQ-029 The displayed value SHALL be mem ? mem_data : pc, selected combinationally.
REQ-030 A scan counter SHALL advance the digit index every SCAN_DIV cycles, wrapping from DIGITS-1 to 0.
REQ-031 When digit i is active, an[i]=0 and all other an bits are 1.
REQ-032 seg SHALL show the hex nibble at value bits [4i+3:4i], with nibbles beyond DATA_W shown as 0; standard hex glyphs are used (C=1000110, D=0100001).
REQ-033 dp=0 only while digit 0 is active and the FSM is in BREAK; otherwise dp=1.
REQ-034 led mapping:
- led[15:14] = FSM state code;
- led[13:8] = 0;
- led[7:0] = ddu_addr, zero-extended or truncated to 8 bits.

Reset
REQ-035 reset_n=0 SHALL asynchronously force: FSM=HALT, run=0, ddu_addr=0, digit index=0, scan counter=0, all debounce state=0, an={(DIGITS-1) ones, 0}, dp=1, led=0.
REQ-036 seg SHALL be combinational from digit 0 while in reset.
REQ-037 Assertion of reset_n=0 in any state, including mid-RUN, SHALL drop run within the same cycle.
REQ-038 Button levels held high across reset release SHALL produce a pulse only after a full debounce window.

Verification
All scenarios use the defaults except SCAN_DIV=4.
REQ-039 reset_n=0 -> run=0, ddu_addr=0x00, an=8'hFE, led=16'h0000, dp=1.
REQ-040 step high for 10 cycles from HALT -> exactly one cycle of run=1, led[15:14]=01 then 00; step toggled every cycle for 3 cycles -> no run pulse.
REQ-041 bkpt_en=1, bkpt_addr=0x10, pc counts +1 per run cycle from 0, cont=1 -> run falls when pc=0x10, led[15:14]=11; then cont=0 -> HALT; then step -> one run cycle.
REQ-042 dec pulse from ddu_addr=0x00 -> 0xFF, led[7:0]=0xFF; inc pulse -> 0x00; simultaneous inc and dec pulses -> unchanged.
REQ-043 mem=0, pc=32'h1234ABCD -> an=8'hFE with seg=0100001 (D); 4 cycles later an=8'hFD with seg=1000110 (C); an returns to 8'hFE after 32 cycles.
REQ-044 reset_n pulsed low during RUN -> run=0 before the next clk edge; FSM resumes from HALT.
